check4_detector: RTL and testbench

- Streaming 4-neighbour feature detector placed between the blanking stage and the image buffer writer in the feature-detection pipeline.
- Consumes one 8-bit grayscale pixel per valid cycle in raster order.
- Marks a pixel as a feature when its up, down, left and right neighbours are all brighter, or all darker, than it by more than THRESHOLD.
- Produces exactly one output pixel per input pixel, so downstream pixel counts are preserved.

---
 rtl/check4_detector.sv | 100 ++++++++++
 tb/tb_check4_detector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/check4_detector.sv
// Streaming 4-neighbour feature detector: flags a pixel whose up/down/left/right
// neighbours are all brighter, or all darker, than it by more than THRESHOLD.
module check4_detector #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int THRESHOLD = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       valid,
  output logic [7:0] dout,
  output logic       validout
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic signed [9:0] THR  = 10'(THRESHOLD);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_a holds row r-1, line_b holds row r-2, both indexed by column
  logic [7:0] line_a [WIDTH];
  logic [7:0] line_b [WIDTH];
  logic [7:0] a_rd;
  logic [7:0] b_rd;

  // Window columns c-1 and c-2; column c comes live from din and the line buffers
  logic [7:0] top1;
  logic [7:0] mid1;
  logic [7:0] mid2;
  logic [7:0] bot1;

  logic [7:0]        nb [4];
  logic signed [9:0] diff [4];
  logic [3:0]        brighter;
  logic [3:0]        darker;
  logic              feature;
  logic              window_ok;

  assign a_rd = line_a[col];
  assign b_rd = line_b[col];

  // Neighbour order: up, down, left, right; centre is mid1
  assign nb[0] = top1;
  assign nb[1] = bot1;
  assign nb[2] = mid2;
  assign nb[3] = a_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cmp
      assign diff[gi]     = $signed({2'b00, nb[gi]}) - $signed({2'b00, mid1});
      assign brighter[gi] = diff[gi] > THR;
      assign darker[gi]   = diff[gi] < -THR;
    end
  endgenerate

  assign feature   = (&brighter) | (&darker);
  assign window_ok = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clock) begin
    if (valid) begin
      line_a[col] <= din;
      line_b[col] <= a_rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      top1     <= '0;
      mid1     <= '0;
      mid2     <= '0;
      bot1     <= '0;
      dout     <= '0;
      validout <= 1'b0;
    end else begin
      validout <= valid;
      if (valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        top1 <= b_rd;
        mid2 <= mid1;
        mid1 <= a_rd;
        bot1 <= din;
        dout <= (window_ok && feature) ? 8'hFF : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_check4_detector.sv
// Self-checking bench for check4_detector: directed images plus random frames
// compared pixel by pixel against a frame-array reference model.
module tb_check4_detector;

  localparam int W = 8;
  localparam int H = 6;
  localparam int T = 20;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       valid = 1'b0;
  logic [7:0] dout;
  logic       validout;

  check4_detector #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(T)) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .valid    (valid),
    .dout     (dout),
    .validout (validout)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  int frame_img [N];
  int model_img [N];
  int model_idx    = 0;
  int last_dout    = 0;
  int ff_seen      = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Feature rule evaluated directly on the received frame at pixel index idx
  function automatic bit model_feature(input int idx);
    int r, c, cen, u, d, l, rt;
    r = idx / W;
    c = idx % W;
    if (r < 2 || c < 2) return 1'b0;
    cen = model_img[(r-1)*W + c-1];
    u   = model_img[(r-2)*W + c-1];
    d   = model_img[r*W + c-1];
    l   = model_img[(r-1)*W + c-2];
    rt  = model_img[(r-1)*W + c];
    if (u > cen + T && d > cen + T && l > cen + T && rt > cen + T) return 1'b1;
    if (u < cen - T && d < cen - T && l < cen - T && rt < cen - T) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit v, input int d);
    int exp;
    int idx;
    valid = v;
    din   = 8'(d);
    idx   = model_idx;
    if (v) begin
      model_img[model_idx] = d;
      exp = model_feature(model_idx) ? 255 : 0;
      model_idx = (model_idx + 1) % N;
    end else begin
      exp = last_dout;
    end
    @(posedge clock);
    #1;
    check_value("validout", int'(validout), int'(v));
    check_value("dout", int'(dout), exp);
    last_dout = exp;
    if (v) begin
      if (dout == 8'hFF) ff_seen++;
      $display("[TB] px r=%0d c=%0d din=%0d dout=%0d exp=%0d", idx / W, idx % W, d, dout, exp);
    end
  endtask

  task automatic fill(input int bg);
    for (int i = 0; i < N; i++) frame_img[i] = bg;
  endtask

  task automatic put(input int r, input int c, input int v);
    frame_img[r*W + c] = v;
  endtask

  task automatic stream_frame(input int gap_pct, input int count);
    for (int i = 0; i < count; i++) begin
      while ($urandom_range(99) < gap_pct) step(1'b0, int'($urandom_range(255)));
      step(1'b1, frame_img[i]);
    end
    valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input int exp_ff);
    ff_seen = 0;
    stream_frame(gap_pct, N);
    check_value(tag, ff_seen, exp_ff);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    reset = 1'b1;
    #2;
    check_value("reset_dout", int'(dout), 0);
    check_value("reset_validout", int'(validout), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    model_idx = 0;
    last_dout = 0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    fill(100);
    run_frame("flat_ff", 0, 0);

    fill(50);  put(2, 3, 200);
    run_frame("bright_ff", 0, 1);

    fill(50);  put(2, 3, 71);
    run_frame("diff21_ff", 0, 1);

    fill(50);  put(2, 3, 70);
    run_frame("diff20_ff", 0, 0);

    fill(200); put(2, 3, 10);
    run_frame("pit_ff", 0, 1);

    fill(200); put(2, 3, 10); put(1, 3, 5);
    run_frame("mixed_ff", 0, 0);

    fill(50);  put(1, 0, 200);
    run_frame("border_ff", 0, 0);

    fill(50);  put(2, 3, 200);
    run_frame("gaps_ff", 30, 1);

    fill(50);
    stream_frame(0, 20);
    do_reset();
    fill(50);  put(2, 3, 200);
    run_frame("midreset_ff", 0, 1);
    run_frame("frame2_ff", 0, 1);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        frame_img[i] = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : 120;
      stream_frame(20, N);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
